// File: rtl/serial_lane_arbiter.sv
// serial_lane_arbiter: shares one 8-bit parallel-to-serial lane among NREQ byte
// sources. At each byte-slot boundary it picks a round-robin winner, or an idle
// filler byte when nobody requests. It then holds that byte on the serializer's
// parallel input for 8 bit-times.
//
// Ports:
//   CLK        rising-edge clock, one serial bit per cycle
//   RESET      asynchronous active-low reset
//   REQ        per-requester byte-pending flags (held until ACK)
//   DATA_IN    byte of requester i on bits [8i+7:8i]
//   IDLE_EN    send IDLE_BYTE in slots with no request
//   ACK        one-hot, one-cycle capture pulse
//   SER_DATA   byte for the serializer, stable for the whole slot
//   SER_VALID  high during every cycle of an active slot
//   SER_LOAD   high on the first cycle of each slot
//   SER_IDLE   high for the whole slot when it carries IDLE_BYTE
//   GRANT_ID   owner of the current slot (0 for idle slots)
//   BIT_CNT    bit position within the current slot
module serial_lane_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned IDW       = 2,
    parameter logic [7:0]  IDLE_BYTE = 8'hBC
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NREQ-1:0]   REQ,
    input  logic [8*NREQ-1:0] DATA_IN,
    input  logic              IDLE_EN,
    output logic [NREQ-1:0]   ACK,
    output logic [7:0]        SER_DATA,
    output logic              SER_VALID,
    output logic              SER_LOAD,
    output logic              SER_IDLE,
    output logic [IDW-1:0]    GRANT_ID,
    output logic [2:0]        BIT_CNT
);

    localparam int unsigned CNTW = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SLOT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [CNTW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              load_q, load_d;
    logic              idle_q, idle_d;
    logic [IDW-1:0]    gid_q, gid_d;
    logic [NREQ-1:0]   ack_q, ack_d;

    logic              found;
    logic [IDW-1:0]    winner;
    logic              decision;

    // Round-robin scan starting at ptr, wrapping at NREQ-1 -> 0.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && REQ[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    // A slot boundary: either nothing is running or the last bit is going out.
    assign decision = (state_q == ST_IDLE) || (bit_cnt_q == CNTW'(7));

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        load_d    = 1'b0;
        idle_d    = idle_q;
        gid_d     = gid_q;
        ack_d     = '0;

        if (decision) begin
            bit_cnt_d = '0;
            if (found) begin
                state_d = ST_SLOT;
                data_d  = DATA_IN[32'(winner)*8 +: 8];
                valid_d = 1'b1;
                load_d  = 1'b1;
                idle_d  = 1'b0;
                gid_d   = winner;
                ack_d   = NREQ'(1) << winner;
                ptr_d   = (32'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);
            end else if (IDLE_EN) begin
                state_d = ST_SLOT;
                data_d  = IDLE_BYTE;
                valid_d = 1'b1;
                load_d  = 1'b1;
                idle_d  = 1'b1;
                gid_d   = '0;
            end else begin
                // Lane goes quiet; SER_DATA keeps the last byte sent.
                state_d = ST_IDLE;
                valid_d = 1'b0;
                idle_d  = 1'b0;
                gid_d   = '0;
            end
        end else begin
            bit_cnt_d = bit_cnt_q + CNTW'(1);
        end
    end

    // State and output registers; reset abandons any slot in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            load_q    <= 1'b0;
            idle_q    <= 1'b0;
            gid_q     <= '0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            load_q    <= load_d;
            idle_q    <= idle_d;
            gid_q     <= gid_d;
            ack_q     <= ack_d;
        end
    end

    assign ACK       = ack_q;
    assign SER_DATA  = data_q;
    assign SER_VALID = valid_q;
    assign SER_LOAD  = load_q;
    assign SER_IDLE  = idle_q;
    assign GRANT_ID  = gid_q;
    assign BIT_CNT   = bit_cnt_q;

endmodule

// File: tb/tb_serial_lane_arbiter.sv
// Bench for serial_lane_arbiter: directed scenarios followed by randomized
// requester traffic, every cycle compared against a slot-level reference model.
module tb_serial_lane_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned IDW    = 2;
    localparam logic [7:0]  IDLE_B = 8'hBC;

    logic              CLK;
    logic              RESET;
    logic [NREQ-1:0]   REQ;
    logic [8*NREQ-1:0] DATA_IN;
    logic              IDLE_EN;
    logic [NREQ-1:0]   ACK;
    logic [7:0]        SER_DATA;
    logic              SER_VALID;
    logic              SER_LOAD;
    logic              SER_IDLE;
    logic [IDW-1:0]    GRANT_ID;
    logic [2:0]        BIT_CNT;

    serial_lane_arbiter #(.NREQ(NREQ), .IDW(IDW), .IDLE_BYTE(IDLE_B)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .DATA_IN(DATA_IN), .IDLE_EN(IDLE_EN),
        .ACK(ACK), .SER_DATA(SER_DATA), .SER_VALID(SER_VALID), .SER_LOAD(SER_LOAD),
        .SER_IDLE(SER_IDLE), .GRANT_ID(GRANT_ID), .BIT_CNT(BIT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors = 0;
    int errs    = 0;

    // Reference model: slot position, rotating priority and expected outputs.
    bit              m_active;
    int              m_pos;
    int              m_ptr;
    logic [7:0]      m_data;
    bit              m_valid, m_load, m_idle;
    int              m_gid;
    logic [NREQ-1:0] m_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_ptr = 0; m_data = 8'h00;
        m_valid = 0; m_load = 0; m_idle = 0; m_gid = 0; m_ack = '0;
    endtask

    task automatic model_step();
        int w;
        if (!RESET) begin
            model_reset();
            return;
        end
        if (m_active && m_pos != 7) begin
            m_pos++;
            m_load = 0;
            m_ack  = '0;
            return;
        end
        w = -1;
        for (int k = 0; k < int'(NREQ); k++) begin
            int i;
            i = (m_ptr + k) % int'(NREQ);
            if (w < 0 && REQ[i]) w = i;
        end
        m_pos = 0;
        m_ack = '0;
        if (w >= 0) begin
            m_active = 1; m_data = DATA_IN[8*w +: 8]; m_valid = 1; m_load = 1;
            m_idle = 0; m_gid = w; m_ack[w] = 1'b1; m_ptr = (w + 1) % int'(NREQ);
        end else if (IDLE_EN) begin
            m_active = 1; m_data = IDLE_B; m_valid = 1; m_load = 1; m_idle = 1; m_gid = 0;
        end else begin
            m_active = 0; m_valid = 0; m_load = 0; m_idle = 0; m_gid = 0;
        end
    endtask

    task automatic compare_all();
        chk("ser_data",  32'(SER_DATA),  32'(m_data));
        chk("ser_valid", 32'(SER_VALID), 32'(m_valid));
        chk("ser_load",  32'(SER_LOAD),  32'(m_load));
        chk("ser_idle",  32'(SER_IDLE),  32'(m_idle));
        chk("grant_id",  32'(GRANT_ID),  32'(m_gid));
        chk("ack",       32'(ACK),       32'(m_ack));
        chk("bit_cnt",   32'(BIT_CNT),   32'(m_pos));
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic async_reset_pulse();
        RESET = 1'b0;
        #1;
        model_reset();
        compare_all();
        RESET = 1'b1;
    endtask

    task automatic run_to_idle();
        int n;
        n = 0;
        while (m_active && n < 20) begin
            tick();
            n++;
        end
        chk("to_idle_valid", 32'(SER_VALID), 32'(0));
    endtask

    logic [1:0] exp5 [3];

    initial begin
        RESET   = 1'b0;
        REQ     = '0;
        DATA_IN = '0;
        IDLE_EN = 1'b0;
        model_reset();
        #2;
        compare_all();
        @(negedge CLK);
        RESET = 1'b1;

        // Quiet lane after reset release.
        repeat (20) tick();

        // Single request from IDLE.
        REQ = 4'b0100;
        DATA_IN[23:16] = 8'hA5;
        tick();
        chk("t2_data", 32'(SER_DATA), 32'hA5);
        chk("t2_gid",  32'(GRANT_ID), 32'd2);
        chk("t2_ack",  32'(ACK), 32'b0100);
        chk("t2_load", 32'(SER_LOAD), 32'd1);
        REQ = '0;
        repeat (7) tick();
        chk("t2_valid_last", 32'(SER_VALID), 32'd1);
        tick();
        chk("t2_valid_end", 32'(SER_VALID), 32'd0);

        // All four requesting: strict rotation, back-to-back slots.
        async_reset_pulse();
        REQ = 4'b1111;
        DATA_IN = {8'h43, 8'h32, 8'h21, 8'h10};
        for (int s = 0; s < 5; s++) begin
            logic [7:0] eb;
            tick();
            eb = 8'h10 + 8'((s % 4) * 8'h11);
            chk("t3_gid",  32'(GRANT_ID), 32'(s % 4));
            chk("t3_data", 32'(SER_DATA), 32'(eb));
            chk("t3_load", 32'(SER_LOAD), 32'd1);
            if (s == 4) REQ = '0;
            repeat (7) tick();
            chk("t3_nogap", 32'(SER_VALID), 32'd1);
        end
        run_to_idle();

        // Idle filler slots, then a request raised mid-slot.
        IDLE_EN = 1'b1;
        tick();
        chk("t4_idle_data", 32'(SER_DATA), 32'hBC);
        chk("t4_idle_flag", 32'(SER_IDLE), 32'd1);
        repeat (7) tick();
        tick();
        chk("t4_idle2", 32'(SER_IDLE), 32'd1);
        repeat (3) tick();
        chk("t4_bitcnt3", 32'(BIT_CNT), 32'd3);
        REQ[1] = 1'b1;
        DATA_IN[15:8] = 8'h5A;
        repeat (4) tick();
        chk("t4_still_idle", 32'(SER_IDLE), 32'd1);
        tick();
        chk("t4_gid",  32'(GRANT_ID), 32'd1);
        chk("t4_data", 32'(SER_DATA), 32'h5A);
        chk("t4_idle", 32'(SER_IDLE), 32'd0);
        REQ = '0;
        IDLE_EN = 1'b0;
        run_to_idle();

        // Pointer wrap: requester 3 held, requester 0 joins.
        REQ[3] = 1'b1;
        DATA_IN[31:24] = 8'h33;
        tick();
        chk("t5_gid_first", 32'(GRANT_ID), 32'd3);
        REQ[0] = 1'b1;
        DATA_IN[7:0] = 8'h0F;
        exp5[0] = 2'd0; exp5[1] = 2'd3; exp5[2] = 2'd0;
        for (int s = 0; s < 3; s++) begin
            repeat (7) tick();
            tick();
            chk("t5_gid", 32'(GRANT_ID), 32'(exp5[s]));
        end
        REQ = '0;
        run_to_idle();

        // Reset in the middle of a requester-1 slot, then a fresh grant.
        REQ[1] = 1'b1;
        DATA_IN[15:8] = 8'h77;
        tick();
        chk("t6_gid", 32'(GRANT_ID), 32'd1);
        repeat (4) tick();
        chk("t6_bitcnt4", 32'(BIT_CNT), 32'd4);
        RESET = 1'b0;
        #1;
        model_reset();
        compare_all();
        tick();
        RESET = 1'b1;
        tick();
        chk("t6_regrant_gid",  32'(GRANT_ID), 32'd1);
        chk("t6_regrant_data", 32'(SER_DATA), 32'h77);
        chk("t6_regrant_ack",  32'(ACK), 32'b0010);
        REQ = '0;
        repeat (7) tick();
        tick();

        // Randomized requester traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (m_ack[i]) begin
                    if ($urandom_range(1, 0) == 0) REQ[i] = 1'b0;
                    else DATA_IN[8*i +: 8] = 8'($urandom);
                end else if (!REQ[i]) begin
                    if ($urandom_range(5, 0) == 0) begin
                        REQ[i] = 1'b1;
                        DATA_IN[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(39, 0) == 0) begin
                    REQ[i] = 1'b0;
                end
            end
            if ($urandom_range(49, 0) == 0) IDLE_EN = ~IDLE_EN;
            if ($urandom_range(299, 0) == 0) begin
                RESET = 1'b0;
                #1;
                model_reset();
                compare_all();
                tick();
                RESET = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
